// File: rtl/rcc_pkg.sv
// -----------------------------------------------------------------------------
// rcc_pkg
//
// Shared definitions for the RCC per-domain reset/clock sequencer:
//   - state encodings of the domain sequencer FSM (also exposed on the debug
//     state output, so the raw codes are kept as named localparams),
//   - reset-cause encodings reported on rst_src,
//   - a helper that sizes the shared HOLD/CLKWAIT/GATE down-counter.
// -----------------------------------------------------------------------------
package rcc_pkg;

    // Raw state codes; the enum below is built on top of these so that the
    // debug output and any external checker agree on the encoding.
    localparam logic [2:0] RCC_ST_OFF     = 3'd0;
    localparam logic [2:0] RCC_ST_HOLD    = 3'd1;
    localparam logic [2:0] RCC_ST_CLKWAIT = 3'd2;
    localparam logic [2:0] RCC_ST_RUN     = 3'd3;
    localparam logic [2:0] RCC_ST_GATE    = 3'd4;

    typedef enum logic [2:0] {
        ST_OFF     = RCC_ST_OFF,
        ST_HOLD    = RCC_ST_HOLD,
        ST_CLKWAIT = RCC_ST_CLKWAIT,
        ST_RUN     = RCC_ST_RUN,
        ST_GATE    = RCC_ST_GATE
    } rcc_state_e;

    // Last reset cause reported on rst_src.
    localparam logic [1:0] RCC_SRC_NONE = 2'b00;
    localparam logic [1:0] RCC_SRC_POR  = 2'b01;
    localparam logic [1:0] RCC_SRC_SW   = 2'b10;
    localparam logic [1:0] RCC_SRC_HW   = 2'b11;

    // Width of the shared down-counter: enough bits to hold the largest
    // (duration - 1) load value, never less than one bit.
    function automatic int rcc_cnt_width(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/rcc_sync_2ff.sv
// -----------------------------------------------------------------------------
// rcc_sync_2ff
//
// Two-flop synchronizer for a single asynchronous level. Both flops clear to 0
// on reset, so a synchronized "ready" style input always starts deasserted.
//
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset (flops clear to 0)
//   d_i    in   asynchronous input level
//   q_o    out  synchronized level, two clk edges of latency
// -----------------------------------------------------------------------------
module rcc_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rcc_dom_rst_seq.sv
// -----------------------------------------------------------------------------
// rcc_dom_rst_seq
//
// Per-power-domain reset/clock sequencer. After power-good (or a reset
// request) the domain is held in reset for RST_DURATION cycles, reset is then
// released, and the domain clock is enabled CLK_ON_AFTER_RST_RELEASE cycles
// later. A warm reset from RUN first gates the clock for GATE_CYCLES cycles
// and only then asserts reset. The cause of the last reset is latched.
//
// Handshake/timing contract: all request inputs are synchronous levels or
// pulses sampled on the rising clk edge; every output is a flop, so outputs
// change only on clk edges (or immediately on rst_n assertion) and there is no
// combinational path from any input to any output.
//
// Ports:
//   clk           in   RCC clock
//   rst_n         in   asynchronous active-low reset (release is pre-synchronized)
//   pwr_rdy       in   domain power-good, asynchronous (synchronized inside)
//   sw_rst_req    in   software reset request, level
//   hw_rst_req    in   hardware reset request, single-cycle pulse
//   rst_flag_clr  in   clears rst_src to "none", pulse
//   dom_rst_n     out  domain reset, active low
//   dom_clk_en    out  domain clock-gate enable
//   dom_ready     out  high only while the domain is in RUN
//   rst_src       out  last reset cause (00 none, 01 POR, 10 SW, 11 HW)
//   dbg_state_o   out  current FSM state code (rcc_pkg RCC_ST_*)
// -----------------------------------------------------------------------------
module rcc_dom_rst_seq
    import rcc_pkg::*;
#(
    parameter int RST_DURATION             = 10,
    parameter int CLK_ON_AFTER_RST_RELEASE = 8,
    parameter int GATE_CYCLES              = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_rdy,
    input  logic       sw_rst_req,
    input  logic       hw_rst_req,
    input  logic       rst_flag_clr,
    output logic       dom_rst_n,
    output logic       dom_clk_en,
    output logic       dom_ready,
    output logic [1:0] rst_src,
    output logic [2:0] dbg_state_o
);

    localparam int CNT_W = rcc_cnt_width(RST_DURATION, CLK_ON_AFTER_RST_RELEASE,
                                         GATE_CYCLES);

    // Counter loads are (duration - 1): the state is left on the edge that
    // samples a count of 0, so each state lasts exactly 'duration' cycles.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_DURATION - 1);
    localparam logic [CNT_W-1:0] CLKW_LOAD = CNT_W'(CLK_ON_AFTER_RST_RELEASE - 1);
    localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES - 1);

    logic             pwr_rdy_s;

    rcc_state_e       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] cnt_dec;
    logic [1:0]       rst_src_q,    rst_src_d;
    logic             dom_rst_n_q,  dom_rst_n_d;
    logic             dom_clk_en_q, dom_clk_en_d;
    logic             dom_ready_q,  dom_ready_d;

    // -------------------------------------------------------------------------
    // Power-good synchronizer
    // -------------------------------------------------------------------------
    rcc_sync_2ff u_pwr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pwr_rdy),
        .q_o   (pwr_rdy_s)
    );

    // Saturating decrement: the shared counter parks at 0 instead of wrapping,
    // which is what lets HOLD sit at count 0 while sw_rst_req is held.
    assign cnt_dec = (cnt_q == '0) ? '0 : (cnt_q - CNT_W'(1));

    // -------------------------------------------------------------------------
    // Next-state, counter and reset-cause logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_src_d = rst_src_q;

        // The clear is applied first so that any cause update below in the
        // same cycle overrides it.
        if (rst_flag_clr) begin
            rst_src_d = RCC_SRC_NONE;
        end

        if (!pwr_rdy_s) begin
            // Power loss wins over everything. Only an actual entry into OFF
            // records a POR cause; idling in OFF leaves rst_src alone.
            state_d = ST_OFF;
            cnt_d   = '0;
            if (state_q != ST_OFF) begin
                rst_src_d = RCC_SRC_POR;
            end
        end else if (hw_rst_req && ((state_q == ST_HOLD) || (state_q == ST_CLKWAIT))) begin
            // Hardware restart while reset is still being sequenced: start
            // the reset hold over from its full length.
            state_d   = ST_HOLD;
            cnt_d     = HOLD_LOAD;
            rst_src_d = RCC_SRC_HW;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end

                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        // A held software request keeps the domain in reset.
                        if (!sw_rst_req) begin
                            state_d = ST_CLKWAIT;
                            cnt_d   = CLKW_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end

                ST_CLKWAIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end

                ST_RUN: begin
                    if (hw_rst_req || sw_rst_req) begin
                        state_d   = ST_GATE;
                        cnt_d     = GATE_LOAD;
                        rst_src_d = hw_rst_req ? RCC_SRC_HW : RCC_SRC_SW;
                    end
                end

                ST_GATE: begin
                    // hw_rst_req is deliberately not looked at here: a reset
                    // is already on its way.
                    if (cnt_q == '0) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end

                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs change on
    // the same edge as the state they belong to.
    // -------------------------------------------------------------------------
    always_comb begin
        dom_rst_n_d  = 1'b0;
        dom_clk_en_d = 1'b0;
        dom_ready_d  = 1'b0;
        unique case (state_d)
            ST_CLKWAIT: begin
                dom_rst_n_d = 1'b1;
            end
            ST_RUN: begin
                dom_rst_n_d  = 1'b1;
                dom_clk_en_d = 1'b1;
                dom_ready_d  = 1'b1;
            end
            ST_GATE: begin
                dom_rst_n_d = 1'b1;
            end
            default: begin
                dom_rst_n_d  = 1'b0;
                dom_clk_en_d = 1'b0;
                dom_ready_d  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers. Reset leaves the domain off with a POR cause.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            rst_src_q    <= RCC_SRC_POR;
            dom_rst_n_q  <= 1'b0;
            dom_clk_en_q <= 1'b0;
            dom_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rst_src_q    <= rst_src_d;
            dom_rst_n_q  <= dom_rst_n_d;
            dom_clk_en_q <= dom_clk_en_d;
            dom_ready_q  <= dom_ready_d;
        end
    end

    assign dom_rst_n   = dom_rst_n_q;
    assign dom_clk_en  = dom_clk_en_q;
    assign dom_ready   = dom_ready_q;
    assign rst_src     = rst_src_q;
    assign dbg_state_o = state_q;

    // -------------------------------------------------------------------------
    // Structural invariants of the sequencer
    // -------------------------------------------------------------------------
    // The clock is only ever enabled while the domain is out of reset.
    a_clk_en_needs_rst_rel: assert property (
        @(posedge clk) disable iff (!rst_n)
        dom_clk_en_q |-> dom_rst_n_q
    );

    // The clock enable never rises together with reset release.
    a_clk_en_after_rst_rel: assert property (
        @(posedge clk) disable iff (!rst_n)
        $rose(dom_clk_en_q) |-> $past(dom_rst_n_q)
    );

    // dom_ready mirrors RUN exactly.
    a_ready_is_run: assert property (
        @(posedge clk) disable iff (!rst_n)
        dom_ready_q == (state_q == ST_RUN)
    );

    // The shared counter is idle (0) whenever no timed state is active.
    a_cnt_idle: assert property (
        @(posedge clk) disable iff (!rst_n)
        ((state_q == ST_OFF) || (state_q == ST_RUN)) |-> (cnt_q == '0)
    );

endmodule

// File: tb/tb_rcc_dom_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_rcc_dom_rst_seq
//
// Each scenario fills a per-edge stimulus schedule, plays it against the DUT
// while recording the outputs after every clk edge, and then compares the
// recorded edge numbers of output transitions against values derived from the
// sequencer rules with plain arithmetic (durations R, C, G and the
// 2-flop + 1-register power-good latency).
//
// Edge numbering inside a trace: index i is the value seen just after the i-th
// clk edge of that trace; schedule entry i is the input level sampled on that
// same edge.
// -----------------------------------------------------------------------------
module tb_rcc_dom_rst_seq;
    import rcc_pkg::*;

    localparam int R    = 10;   // RST_DURATION
    localparam int C    = 8;    // CLK_ON_AFTER_RST_RELEASE
    localparam int G    = 2;    // GATE_CYCLES
    localparam int TMAX = 255;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwr_rdy;
    logic       sw_rst_req;
    logic       hw_rst_req;
    logic       rst_flag_clr;
    logic       dom_rst_n;
    logic       dom_clk_en;
    logic       dom_ready;
    logic [1:0] rst_src;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    rcc_dom_rst_seq #(
        .RST_DURATION             (R),
        .CLK_ON_AFTER_RST_RELEASE (C),
        .GATE_CYCLES              (G)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwr_rdy      (pwr_rdy),
        .sw_rst_req   (sw_rst_req),
        .hw_rst_req   (hw_rst_req),
        .rst_flag_clr (rst_flag_clr),
        .dom_rst_n    (dom_rst_n),
        .dom_clk_en   (dom_clk_en),
        .dom_ready    (dom_ready),
        .rst_src      (rst_src),
        .dbg_state_o  (dbg_state)
    );

    // -------------------------------------------------------------------------
    // Bookkeeping, schedules, traces, expected-cause queue
    // -------------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    logic       sc_sw  [0:TMAX];
    logic       sc_hw  [0:TMAX];
    logic       sc_clr [0:TMAX];
    logic       sc_pwr [0:TMAX];

    logic       tr_rst [0:TMAX];
    logic       tr_clk [0:TMAX];
    logic       tr_rdy [0:TMAX];
    logic [1:0] tr_src [0:TMAX];
    logic [2:0] tr_st  [0:TMAX];

    logic [1:0] exp_q[$];

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic sched_clear();
        for (int i = 0; i <= TMAX; i++) begin
            sc_sw[i]  = 1'b0;
            sc_hw[i]  = 1'b0;
            sc_clr[i] = 1'b0;
            sc_pwr[i] = 1'b1;
        end
    endtask

    // Called at (posedge + 1): drives schedule entry i, waits for edge i,
    // samples 1 time unit after it.
    task automatic run_trace(input int n);
        for (int i = 1; i <= n; i++) begin
            sw_rst_req   = sc_sw[i];
            hw_rst_req   = sc_hw[i];
            rst_flag_clr = sc_clr[i];
            pwr_rdy      = sc_pwr[i];
            @(posedge clk);
            #1;
            tr_rst[i] = dom_rst_n;
            tr_clk[i] = dom_clk_en;
            tr_rdy[i] = dom_ready;
            tr_src[i] = rst_src;
            tr_st[i]  = dbg_state;
        end
        sw_rst_req   = 1'b0;
        hw_rst_req   = 1'b0;
        rst_flag_clr = 1'b0;
    endtask

    // First trace index in [from, to] where the selected output equals val;
    // -1 if it never does (a missing transition shows up as a mismatch).
    function automatic int first_idx(input int sel, input logic val, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            if (sel == 0 && tr_rst[i] === val) return i;
            if (sel == 1 && tr_clk[i] === val) return i;
            if (sel == 2 && tr_rdy[i] === val) return i;
        end
        return -1;
    endfunction

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n        = 1'b0;
        pwr_rdy      = 1'b0;
        sw_rst_req   = 1'b0;
        hw_rst_req   = 1'b0;
        rst_flag_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (dom_rst_n !== 1'b0) $display("FAIL reset_dom_rst_n: got %b expected 0", dom_rst_n);
        else n_pass++;
        n_total++;
        if (dom_clk_en !== 1'b0) $display("FAIL reset_dom_clk_en: got %b expected 0", dom_clk_en);
        else n_pass++;
        n_total++;
        if (dom_ready !== 1'b0) $display("FAIL reset_dom_ready: got %b expected 0", dom_ready);
        else n_pass++;
        n_total++;
        if (rst_src !== 2'b01) $display("FAIL reset_rst_src: got %b expected 01", rst_src);
        else n_pass++;
        n_total++;
        if (dbg_state !== RCC_ST_OFF) $display("FAIL reset_state: got %0d expected %0d", dbg_state, RCC_ST_OFF);
        else n_pass++;
    endtask

    task automatic test_cold_start();
        int len;
        int got;
        sched_clear();
        len = 3 + R + C + 3;
        rst_n = 1'b1;
        run_trace(len);
        got = first_idx(0, 1'b1, 1, len);
        n_total++;
        if (got !== 3 + R) $display("FAIL cold_rst_rise: got edge %0d expected %0d", got, 3 + R);
        else n_pass++;
        got = first_idx(1, 1'b1, 1, len);
        n_total++;
        if (got !== 3 + R + C) $display("FAIL cold_clk_rise: got edge %0d expected %0d", got, 3 + R + C);
        else n_pass++;
        got = first_idx(2, 1'b1, 1, len);
        n_total++;
        if (got !== 3 + R + C) $display("FAIL cold_ready_rise: got edge %0d expected %0d", got, 3 + R + C);
        else n_pass++;
        got = first_idx(0, 1'b0, 3 + R, len);
        n_total++;
        if (got !== -1) $display("FAIL cold_rst_stays_high: got fall at edge %0d expected none", got);
        else n_pass++;
        n_total++;
        if (tr_src[len] !== 2'b01) $display("FAIL cold_rst_src: got %b expected 01", tr_src[len]);
        else n_pass++;
    endtask

    // Random single-cycle warm resets from RUN: SW only, HW only, or both.
    task automatic test_warm_reset();
        int         k;
        int         kind;
        int         len;
        int         got;
        logic [1:0] exp_src;
        for (int it = 0; it < 4; it++) begin
            sched_clear();
            k    = $urandom_range(1, 4);
            kind = $urandom_range(0, 2);
            sc_sw[k] = (kind != 1);
            sc_hw[k] = (kind != 0);
            exp_q.push_back((kind == 0) ? 2'b10 : 2'b11);
            len = k + G + R + C + 2;
            run_trace(len);
            got = first_idx(1, 1'b0, 1, len);
            n_total++;
            if (got !== k) $display("FAIL warm_clk_fall[%0d]: got edge %0d expected %0d", it, got, k);
            else n_pass++;
            got = first_idx(2, 1'b0, 1, len);
            n_total++;
            if (got !== k) $display("FAIL warm_ready_fall[%0d]: got edge %0d expected %0d", it, got, k);
            else n_pass++;
            got = first_idx(0, 1'b0, 1, len);
            n_total++;
            if (got !== k + G) $display("FAIL warm_rst_fall[%0d]: got edge %0d expected %0d", it, got, k + G);
            else n_pass++;
            got = first_idx(0, 1'b1, k + G, len);
            n_total++;
            if (got !== k + G + R) $display("FAIL warm_rst_rise[%0d]: got edge %0d expected %0d", it, got, k + G + R);
            else n_pass++;
            got = first_idx(1, 1'b1, k, len);
            n_total++;
            if (got !== k + G + R + C) $display("FAIL warm_clk_rise[%0d]: got edge %0d expected %0d", it, got, k + G + R + C);
            else n_pass++;
            exp_src = exp_q.pop_front();
            n_total++;
            if (tr_src[k] !== exp_src) $display("FAIL warm_rst_src[%0d]: got %b expected %b", it, tr_src[k], exp_src);
            else n_pass++;
        end
    endtask

    // Software request held well past the nominal HOLD length.
    task automatic test_sw_held();
        int h;
        int len;
        int got;
        int exp_rise;
        sched_clear();
        h = $urandom_range(15, 30);
        for (int i = 1; i <= h; i++) sc_sw[i] = 1'b1;
        exp_rise = (h + 1 > 1 + G + R) ? h + 1 : 1 + G + R;
        len = exp_rise + C + 3;
        run_trace(len);
        got = first_idx(0, 1'b0, 1, len);
        n_total++;
        if (got !== 1 + G) $display("FAIL held_rst_fall: got edge %0d expected %0d", got, 1 + G);
        else n_pass++;
        got = first_idx(0, 1'b1, 1 + G, len);
        n_total++;
        if (got !== exp_rise) $display("FAIL held_rst_rise: got edge %0d expected %0d (held %0d)", got, exp_rise, h);
        else n_pass++;
        got = first_idx(1, 1'b1, 1, len);
        n_total++;
        if (got !== exp_rise + C) $display("FAIL held_clk_rise: got edge %0d expected %0d", got, exp_rise + C);
        else n_pass++;
        n_total++;
        if (tr_src[len] !== 2'b10) $display("FAIL held_rst_src: got %b expected 10", tr_src[len]);
        else n_pass++;
    endtask

    // HW pulse during HOLD restarts the full hold; first at count 3, then random.
    task automatic test_hw_restart();
        int p;
        int len;
        int got;
        for (int it = 0; it < 2; it++) begin
            sched_clear();
            sc_sw[1] = 1'b1;
            p = (it == 0) ? (G + R - 2) : $urandom_range(2 + G, 1 + G + R);
            sc_hw[p] = 1'b1;
            len = p + R + C + 3;
            run_trace(len);
            got = first_idx(0, 1'b0, 1, len);
            n_total++;
            if (got !== 1 + G) $display("FAIL hwr_rst_fall[%0d]: got edge %0d expected %0d", it, got, 1 + G);
            else n_pass++;
            got = first_idx(0, 1'b1, 1 + G, len);
            n_total++;
            if (got !== p + R) $display("FAIL hwr_rst_rise[%0d]: got edge %0d expected %0d", it, got, p + R);
            else n_pass++;
            got = first_idx(1, 1'b1, 1, len);
            n_total++;
            if (got !== p + R + C) $display("FAIL hwr_clk_rise[%0d]: got edge %0d expected %0d", it, got, p + R + C);
            else n_pass++;
            n_total++;
            if (tr_src[p - 1] !== 2'b10) $display("FAIL hwr_src_before[%0d]: got %b expected 10", it, tr_src[p - 1]);
            else n_pass++;
            n_total++;
            if (tr_src[p] !== 2'b11) $display("FAIL hwr_src_after[%0d]: got %b expected 11", it, tr_src[p]);
            else n_pass++;
        end
    endtask

    // HW pulse while already gating is ignored: timing and cause unchanged.
    task automatic test_hw_in_gate();
        int len;
        int got;
        sched_clear();
        sc_sw[1] = 1'b1;
        sc_hw[2] = 1'b1;
        len = 1 + G + R + C + 3;
        run_trace(len);
        got = first_idx(0, 1'b0, 1, len);
        n_total++;
        if (got !== 1 + G) $display("FAIL gatehw_rst_fall: got edge %0d expected %0d", got, 1 + G);
        else n_pass++;
        got = first_idx(0, 1'b1, 1 + G, len);
        n_total++;
        if (got !== 1 + G + R) $display("FAIL gatehw_rst_rise: got edge %0d expected %0d", got, 1 + G + R);
        else n_pass++;
        n_total++;
        if (tr_src[len] !== 2'b10) $display("FAIL gatehw_rst_src: got %b expected 10", tr_src[len]);
        else n_pass++;
    endtask

    // Clear colliding with a HW cause loses; a clear on its own wins.
    task automatic test_flag_clear();
        int len;
        int got;
        sched_clear();
        sc_hw[1]  = 1'b1;
        sc_clr[1] = 1'b1;
        sc_clr[3] = 1'b1;
        len = 1 + G + R + C + 3;
        run_trace(len);
        n_total++;
        if (tr_src[1] !== 2'b11) $display("FAIL clr_collision: got %b expected 11", tr_src[1]);
        else n_pass++;
        n_total++;
        if (tr_src[2] !== 2'b11) $display("FAIL clr_hold_value: got %b expected 11", tr_src[2]);
        else n_pass++;
        n_total++;
        if (tr_src[3] !== 2'b00) $display("FAIL clr_alone: got %b expected 00", tr_src[3]);
        else n_pass++;
        n_total++;
        if (tr_src[len] !== 2'b00) $display("FAIL clr_sticky: got %b expected 00", tr_src[len]);
        else n_pass++;
        got = first_idx(1, 1'b1, 1, len);
        n_total++;
        if (got !== 1 + G + R + C) $display("FAIL clr_clk_rise: got edge %0d expected %0d", got, 1 + G + R + C);
        else n_pass++;
    endtask

    // Power drop during CLKWAIT, cold restart, then a drop from RUN.
    task automatic test_pwr_drop();
        int d;
        int u;
        int e;
        int v;
        int len;
        int got;
        sched_clear();
        sc_sw[1] = 1'b1;
        d = $urandom_range(G + R, G + R + C - 1);
        u = d + 6;
        for (int i = d; i < u; i++) sc_pwr[i] = 1'b0;
        e = u + 2 + R + C + 2;
        v = e + 4;
        for (int i = e; i < v; i++) sc_pwr[i] = 1'b0;
        len = v + 2 + R + C + 2;
        run_trace(len);
        n_total++;
        if (tr_rst[d + 1] !== 1'b1) $display("FAIL pwr1_rst_before: got %b expected 1", tr_rst[d + 1]);
        else n_pass++;
        n_total++;
        if (tr_rst[d + 2] !== 1'b0 || tr_clk[d + 2] !== 1'b0)
            $display("FAIL pwr1_outputs: got rst_n=%b clk_en=%b expected 0 0", tr_rst[d + 2], tr_clk[d + 2]);
        else n_pass++;
        n_total++;
        if (tr_st[d + 2] !== RCC_ST_OFF) $display("FAIL pwr1_state: got %0d expected %0d", tr_st[d + 2], RCC_ST_OFF);
        else n_pass++;
        n_total++;
        if (tr_src[d + 1] !== 2'b10 || tr_src[d + 2] !== 2'b01)
            $display("FAIL pwr1_rst_src: got %b then %b expected 10 then 01", tr_src[d + 1], tr_src[d + 2]);
        else n_pass++;
        got = first_idx(0, 1'b1, d + 2, len);
        n_total++;
        if (got !== u + 2 + R) $display("FAIL pwr1_rst_rise: got edge %0d expected %0d", got, u + 2 + R);
        else n_pass++;
        got = first_idx(1, 1'b1, d + 2, len);
        n_total++;
        if (got !== u + 2 + R + C) $display("FAIL pwr1_clk_rise: got edge %0d expected %0d", got, u + 2 + R + C);
        else n_pass++;
        n_total++;
        if (tr_rst[e + 1] !== 1'b1 || tr_clk[e + 1] !== 1'b1)
            $display("FAIL pwr2_before: got rst_n=%b clk_en=%b expected 1 1", tr_rst[e + 1], tr_clk[e + 1]);
        else n_pass++;
        n_total++;
        if (tr_rst[e + 2] !== 1'b0 || tr_clk[e + 2] !== 1'b0)
            $display("FAIL pwr2_together: got rst_n=%b clk_en=%b expected 0 0", tr_rst[e + 2], tr_clk[e + 2]);
        else n_pass++;
        n_total++;
        if (tr_src[e + 2] !== 2'b01) $display("FAIL pwr2_rst_src: got %b expected 01", tr_src[e + 2]);
        else n_pass++;
        got = first_idx(1, 1'b1, e + 2, len);
        n_total++;
        if (got !== v + 2 + R + C) $display("FAIL pwr2_clk_rise: got edge %0d expected %0d", got, v + 2 + R + C);
        else n_pass++;
    endtask

    // rst_n assertion mid-cycle forces the reset values without a clk edge.
    task automatic test_async_reset();
        sched_clear();
        sc_clr[1] = 1'b1;
        run_trace(2);
        n_total++;
        if (tr_src[2] !== 2'b00 || tr_clk[2] !== 1'b1)
            $display("FAIL async_pre: got src=%b clk_en=%b expected 00 1", tr_src[2], tr_clk[2]);
        else n_pass++;
        rst_n = 1'b0;
        #2;
        n_total++;
        if (dom_rst_n !== 1'b0 || dom_clk_en !== 1'b0 || dom_ready !== 1'b0)
            $display("FAIL async_outputs: got rst_n=%b clk_en=%b ready=%b expected 0 0 0",
                     dom_rst_n, dom_clk_en, dom_ready);
        else n_pass++;
        n_total++;
        if (rst_src !== 2'b01) $display("FAIL async_rst_src: got %b expected 01", rst_src);
        else n_pass++;
        n_total++;
        if (dbg_state !== RCC_ST_OFF) $display("FAIL async_state: got %0d expected %0d", dbg_state, RCC_ST_OFF);
        else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_cold_start();
        test_warm_reset();
        test_sw_held();
        test_hw_restart();
        test_hw_in_gate();
        test_flag_clear();
        test_pwr_drop();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rcc_dom_rst_seq.md
# rcc_dom_rst_seq

Per-power-domain reset/clock sequencer in the RCC. It sits directly upstream of the domain reset/clock-gate fabric that `rcc_vcore_top` distributes. It holds the domain in reset for a fixed duration after power-good or a reset request, releases reset, and enables the domain clock a fixed number of cycles later. It gates the clock before asserting reset on warm resets and latches the last reset cause.

## Interface
- `RST_DURATION`, 10: cycles `dom_rst_n` is held low in HOLD; legal range ≥1.
- `CLK_ON_AFTER_RST_RELEASE`, 8: cycles between `dom_rst_n` rising and `dom_clk_en` rising; legal range ≥1.
- `GATE_CYCLES`, 2: cycles the clock is gated before reset assertion on a warm reset; legal range ≥1.

- `clk`, in, 1: RCC clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pwr_rdy`, in, 1: domain power-good; asynchronous, double-flop synchronized internally to `pwr_rdy_s`.
- `sw_rst_req`, in, 1: software reset request; level, synchronous.
- `hw_rst_req`, in, 1: hardware reset request (e.g. watchdog); single-cycle pulse, synchronous.
- `rst_flag_clr`, in, 1: clears `rst_src`; pulse.
- `dom_rst_n`, out, 1: domain reset, active-low, registered.
- `dom_clk_en`, out, 1: domain clock-gate enable, registered.
- `dom_ready`, out, 1: high in RUN only.
- `rst_src`, out, 2: last reset cause. Encodings: 00 none, 01 power/POR, 10 SW, 11 HW.

## Operation
- States: OFF, HOLD, CLKWAIT, RUN, GATE. A down-counter is shared by HOLD, CLKWAIT and GATE.
- OFF: `dom_rst_n`=0, `dom_clk_en`=0. When `pwr_rdy_s`=1, go to HOLD and load the counter with RST_DURATION-1.
- HOLD: `dom_rst_n`=0, `dom_clk_en`=0.
  - Decrement each cycle.
  - At count 0 with `sw_rst_req`=0, go to CLKWAIT and load CLK_ON_AFTER_RST_RELEASE-1.
  - At count 0 with `sw_rst_req`=1, stay in HOLD with count at 0 until the request drops.
- CLKWAIT: `dom_rst_n`=1, `dom_clk_en`=0. Decrement; at count 0, go to RUN.
- RUN: `dom_rst_n`=1, `dom_clk_en`=1, `dom_ready`=1. If `hw_rst_req` or `sw_rst_req` is high, go to GATE and load GATE_CYCLES-1.
- GATE: `dom_rst_n`=1, `dom_clk_en`=0. At count 0, go to HOLD and reload RST_DURATION-1.
- Priority each cycle:
  1. `pwr_rdy_s`=0 forces OFF from any state.
  2. `hw_rst_req` in HOLD or CLKWAIT goes to HOLD and reloads the full RST_DURATION.
  3. `hw_rst_req` in GATE is ignored; the reset is already pending.
  4. Normal transitions.
- `rst_src` updates:
  - Set to 01 on entry to OFF caused by a power drop, and on `rst_n` deassertion.
  - Set to 11 on a `hw_rst_req` acted on.
  - Set to 10 on a RUN→GATE transition caused only by `sw_rst_req`; HW wins if both are high.
  - `rst_flag_clr` sets 00. A simultaneous cause update wins over the clear.
- Counter width is `$clog2(max(RST_DURATION, CLK_ON_AFTER_RST_RELEASE, GATE_CYCLES))`, minimum 1. The counter never wraps; it holds at 0.

## Timing
- Values while `rst_n`=0: state OFF, `dom_rst_n`=0, `dom_clk_en`=0, `dom_ready`=0, `rst_src`=01, counter 0, synchronizer flops 0.
- Assertion of `rst_n` forces these values immediately (asynchronous). Deassertion is internally re-timed by the caller-supplied synchronous release.
- `pwr_rdy` rise to HOLD entry: 3 clock edges (2 synchronizer + 1 FSM).
- HOLD lasts exactly RST_DURATION cycles, CLKWAIT exactly CLK_ON_AFTER_RST_RELEASE cycles, GATE exactly GATE_CYCLES cycles.
- `pwr_rdy` fall to OFF: 3 edges. Outputs drop on that same edge, registered.
- All outputs are registered; there is no combinational input-to-output path.
- `dom_clk_en` never rises in the same cycle as `dom_rst_n`.
- `dom_clk_en` always falls at least GATE_CYCLES cycles before `dom_rst_n` falls on warm reset. The exception is power loss, where both fall together.

## Structure
- Package `rcc_pkg` holds:
  - the state encoding localparams;
  - the `rst_src` encodings: `RCC_SRC_NONE`, `RCC_SRC_POR`, `RCC_SRC_SW`, `RCC_SRC_HW`.
- Sub-module `rcc_sync_2ff`: 2-flop synchronizer with async active-low reset to 0, reused for `pwr_rdy`.
- The FSM and counter stay inline in `rcc_dom_rst_seq`.

## Test plan
- Cold start: release `rst_n`, raise `pwr_rdy` before edge 1, all parameters at default.
  - `dom_rst_n` rises at edge 13.
  - `dom_clk_en` and `dom_ready` rise at edge 21.
  - `rst_src`=01.
- SW warm reset: pulse `sw_rst_req` for 1 cycle in RUN.
  - `dom_clk_en` falls the next edge.
  - `dom_rst_n` falls 2 edges later and stays low 10 cycles.
  - `dom_clk_en` returns 8 cycles after release.
  - `rst_src`=10.
- SW held: keep `sw_rst_req` high for 30 cycles.
  - HOLD extends until the request drops.
  - CLKWAIT then takes 8 cycles.
- HW restart: pulse `hw_rst_req` at HOLD count 3.
  - HOLD reloads; total `dom_rst_n`-low time is the elapsed cycles plus 10.
  - `rst_src`=11.
- Power drop in CLKWAIT: drop `pwr_rdy`.
  - 3 edges later `dom_rst_n`=0, `dom_clk_en`=0, state OFF, `rst_src`=01.
  - Raise `pwr_rdy` again: the full cold sequence repeats.
- Flag clear collision: assert `rst_flag_clr` and `hw_rst_req` on the same RUN cycle.
  - `rst_src`=11.
  - A later clear alone gives 00.
